// File: rtl/tb_wr_memory.sv
// Testbench sink memory: accepts a valid/ready stream into auto-incrementing
// addresses with programmable backpressure, a beat limit and a readback port.
module tb_wr_memory #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned MemDepth   = 1024,
    parameter int unsigned StallWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [AddrWidth-1:0]  wr_limit_i,
    input  logic [StallWidth-1:0] stall_cycles_i,
    input  logic [AddrWidth-1:0]  rd_addr_i,
    output logic [DataWidth-1:0]  rd_data_o,
    input  logic [DataWidth-1:0]  wr_acc_data_i,
    input  logic                  wr_acc_valid_i,
    output logic                  wr_acc_ready_o,
    output logic [AddrWidth-1:0]  wr_acc_addr_o,
    output logic                  done_o
);

    localparam int unsigned IdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [AddrWidth-1:0] DepthA = AddrWidth'(MemDepth);

    typedef enum logic [1:0] {IDLE, RECV, STALL, DONE} state_e;

    state_e                state_q, state_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [AddrWidth-1:0]  limit_q, limit_d;
    logic [StallWidth-1:0] stall_q, stall_d;
    logic [DataWidth-1:0]  mem_q [MemDepth];
    logic                  we;
    logic [AddrWidth-1:0]  addr_inc;
    logic [AddrWidth-1:0]  eff_limit;

    assign addr_inc  = addr_q + AddrWidth'(1);
    // Zero or oversize limits clamp to the depth so writes stay in range.
    assign eff_limit = (wr_limit_i == '0 || wr_limit_i > DepthA) ? DepthA : wr_limit_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            limit_q <= DepthA;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            limit_q <= limit_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MemDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr_q[IdxW-1:0]] <= wr_acc_data_i;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        limit_d        = limit_q;
        stall_d        = stall_q;
        we             = 1'b0;
        wr_acc_ready_o = 1'b0;
        done_o         = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            addr_d  = '0;
            stall_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    addr_d  = '0;
                    limit_d = eff_limit;
                    state_d = RECV;
                end
                RECV: begin
                    wr_acc_ready_o = 1'b1;
                    if (wr_acc_valid_i) begin
                        we     = 1'b1;
                        addr_d = addr_inc;
                        if (addr_inc == limit_q) begin
                            state_d = DONE;
                        end else if (stall_cycles_i != '0) begin
                            stall_d = stall_cycles_i;
                            state_d = STALL;
                        end
                    end
                end
                STALL: begin
                    if (stall_q <= StallWidth'(1)) begin
                        stall_d = '0;
                        state_d = RECV;
                    end else begin
                        stall_d = stall_q - StallWidth'(1);
                    end
                end
                DONE: begin
                    done_o = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign wr_acc_addr_o = addr_q;

    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i < DepthA) begin
            rd_data_o = mem_q[rd_addr_i[IdxW-1:0]];
        end
    end

endmodule

// File: tb/tb_tb_wr_memory.sv
// Directed self-checking bench for tb_wr_memory (8-word memory).
module tb_tb_wr_memory;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] limit;
    logic [SW-1:0] stall;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic          done;

    int checks = 0;
    int errors = 0;

    tb_wr_memory #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .MemDepth  (8),
        .StallWidth(SW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .wr_limit_i    (limit),
        .stall_cycles_i(stall),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .wr_acc_data_i (data),
        .wr_acc_valid_i(valid),
        .wr_acc_ready_o(ready),
        .wr_acc_addr_o (addr),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        valid;
        logic [31:0] data;
        logic [7:0]  stall;
        logic [31:0] limit;
        logic        exp_ready;
        logic [31:0] exp_addr;
        logic        exp_done;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input int unsigned a, input logic [31:0] exp);
        @(negedge clk);
        rd_addr = a;
        #1;
        chk($sformatf("mem[%0d]", a), rd_data, exp);
    endtask

    // Drive at negedge, check ready mid-low-phase, then check post-edge state.
    task automatic cyc(input string name, input logic e, input logic v, input logic [31:0] d,
                       input logic exp_ready);
        @(negedge clk);
        en = e; valid = v; data = d;
        #1;
        chk({name, " ready"}, {31'b0, ready}, {31'b0, exp_ready});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; limit = '0; stall = '0; rd_addr = '0;
        data = '0; valid = 1'b0;

        vecs[0]  = '{1, 1, 32'hA0, 0, 4, 0, 0, 0};
        vecs[1]  = '{1, 1, 32'hA0, 0, 4, 1, 1, 0};
        vecs[2]  = '{1, 1, 32'hA1, 0, 4, 1, 2, 0};
        vecs[3]  = '{1, 1, 32'hA2, 0, 4, 1, 3, 0};
        vecs[4]  = '{1, 1, 32'hA3, 0, 4, 1, 4, 1};
        vecs[5]  = '{1, 1, 32'hEE, 0, 4, 0, 4, 1};
        vecs[6]  = '{0, 0, 32'h00, 0, 4, 0, 0, 0};
        vecs[7]  = '{1, 1, 32'h11, 0, 4, 0, 0, 0};
        vecs[8]  = '{1, 1, 32'h11, 0, 4, 1, 1, 0};
        vecs[9]  = '{1, 0, 32'hFF, 0, 4, 1, 1, 0};
        vecs[10] = '{1, 1, 32'h22, 0, 4, 1, 2, 0};
        vecs[11] = '{1, 0, 32'hFF, 0, 4, 1, 2, 0};
        vecs[12] = '{0, 0, 32'h00, 0, 4, 0, 0, 0};

        #12;
        chk("reset ready", {31'b0, ready}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset addr", addr, 32'd0);
        chk("reset rd", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back then sparse valid
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            en = vecs[i].en; valid = vecs[i].valid; data = vecs[i].data;
            stall = vecs[i].stall; limit = vecs[i].limit;
            #1;
            chk($sformatf("v%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d addr", i), addr, vecs[i].exp_addr);
            chk($sformatf("v%0d done", i), {31'b0, done}, {31'b0, vecs[i].exp_done});
        end
        chk_mem(0, 32'h11);
        chk_mem(1, 32'h22);
        chk_mem(2, 32'hA2);
        chk_mem(3, 32'hA3);

        // Stall insertion: stall=2, limit=3; stall input changes during STALL are ignored
        begin
            logic pat [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
            int beats = 0;
            stall = 2; limit = 3;
            cyc("stall idle", 1, 1, 32'hB0, 0);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                data  = 32'hB0 + beats;
                stall = pat[i] ? 8'd2 : 8'd7;
                #1;
                chk($sformatf("stall pat%0d", i), {31'b0, ready}, {31'b0, pat[i]});
                if (pat[i]) beats++;
                @(posedge clk);
                #1;
            end
            chk("stall done", {31'b0, done}, 32'd1);
            chk("stall addr", addr, 32'd3);
            cyc("stall off", 0, 0, 0, 0);
            chk_mem(0, 32'hB0);
            chk_mem(1, 32'hB1);
            chk_mem(2, 32'hB2);
        end

        // Limit clamp with wr_limit 0 and 20 on an 8-deep memory
        for (int pass = 0; pass < 2; pass++) begin
            logic [31:0] base = (pass == 0) ? 32'hC0 : 32'hD0;
            stall = 0; limit = (pass == 0) ? 32'd0 : 32'd20;
            cyc("clamp idle", 1, 1, base, 0);
            for (int k = 0; k < 8; k++) begin
                cyc($sformatf("clamp%0d b%0d", pass, k), 1, 1, base + k, 1);
                if (k == 6) chk("clamp not done", {31'b0, done}, 32'd0);
            end
            chk("clamp done", {31'b0, done}, 32'd1);
            chk("clamp addr", addr, 32'd8);
            cyc("clamp extra", 1, 1, 32'hEE, 0);
            chk("clamp addr hold", addr, 32'd8);
            cyc("clamp off", 0, 0, 0, 0);
            chk_mem(7, base + 7);
            chk_mem(0, base);
            chk_mem(8, 32'd0);
        end

        // Enable drop mid-stream
        stall = 0; limit = 4;
        cyc("edrop idle", 1, 1, 32'h60, 0);
        cyc("edrop b0", 1, 1, 32'h60, 1);
        cyc("edrop b1", 1, 1, 32'h61, 1);
        chk("edrop addr2", addr, 32'd2);
        cyc("edrop low", 0, 1, 32'h77, 0);
        chk("edrop addr0", addr, 32'd0);
        chk("edrop done", {31'b0, done}, 32'd0);
        cyc("edrop reidle", 1, 1, 32'h55, 0);
        cyc("edrop new", 1, 1, 32'h55, 1);
        chk("edrop addr1", addr, 32'd1);
        chk("edrop done2", {31'b0, done}, 32'd0);
        cyc("edrop hold", 1, 0, 32'h00, 1);
        chk_mem(0, 32'h55);
        chk_mem(1, 32'h61);

        // Async reset during STALL
        cyc("ares off", 0, 0, 0, 0);
        stall = 3; limit = 4;
        cyc("ares idle", 1, 1, 32'h99, 0);
        cyc("ares b0", 1, 1, 32'h99, 1);
        cyc("ares stall", 1, 1, 32'h9A, 0);
        chk("ares pre addr", addr, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ares ready", {31'b0, ready}, 32'd0);
        chk("ares addr", addr, 32'd0);
        chk("ares done", {31'b0, done}, 32'd0);
        en = 1'b0; valid = 1'b0;
        for (int a = 0; a < 8; a++) chk_mem(a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
